// File: rtl/csr_seq_pkg.sv
// Shared types for the CSR access sequencer: Zicsr operation encoding and FSM states.
package csr_seq_pkg;

  typedef enum logic [1:0] {
    CSR_OP_RSVD = 2'd0,
    CSR_OP_RW   = 2'd1,
    CSR_OP_RS   = 2'd2,
    CSR_OP_RC   = 2'd3
  } csr_op_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } csr_seq_state_t;

endpackage

// File: rtl/csr_access_check.sv
// Decodes whether a CSR address is implemented and, for the write flavour,
// whether it is writable (addr[11:10] == 2'b11 marks the read-only space).
module csr_access_check #(
  parameter int ADDR_WIDTH       = 12,
  parameter bit WRITE_PREMISSION = 1'b0
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic                  ok
);

  logic [11:0] a12;
  logic        known;

  assign a12 = addr[11:0];

  always_comb begin
    known = 1'b0;
    case (a12)
      12'h300, 12'h301, 12'h304, 12'h305,
      12'h340, 12'h341, 12'h342, 12'h343, 12'h344,
      12'hF11, 12'hF12, 12'hF13, 12'hF14: known = 1'b1;
      default:                            known = 1'b0;
    endcase
  end

  assign ok = WRITE_PREMISSION ? (known && (a12[11:10] != 2'b11)) : known;

endmodule

// File: rtl/csr_access_sequencer.sv
// Executes one Zicsr instruction at a time: permission check, old-value read,
// read-modify-write, then result return, with flush abort from any busy state.
`ifndef CSR_ADDR_WIDTH
`define CSR_ADDR_WIDTH 12
`endif

module csr_access_sequencer
  import csr_seq_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = `CSR_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [1:0]            req_op,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_src,
  input  logic                  req_wr_en,
  input  logic                  flush,
  output logic [ADDR_WIDTH-1:0] csrf_raddr,
  input  logic [DATA_WIDTH-1:0] csrf_rdata,
  output logic                  csrf_we,
  output logic [ADDR_WIDTH-1:0] csrf_waddr,
  output logic [DATA_WIDTH-1:0] csrf_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_illegal
);

  csr_seq_state_t        state_q, state_d;
  csr_op_t               op_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] src_q;
  logic [DATA_WIDTH-1:0] old_q;
  logic                  wr_en_q;
  logic                  illegal_q;
  logic                  rd_ok, wr_ok;
  logic                  accept;
  logic                  illegal;

  function automatic logic [DATA_WIDTH-1:0] rmw_data(input csr_op_t op,
                                                     input logic [DATA_WIDTH-1:0] old,
                                                     input logic [DATA_WIDTH-1:0] src);
    case (op)
      CSR_OP_RW: return src;
      CSR_OP_RS: return old | src;
      CSR_OP_RC: return old & ~src;
      default:   return '0;
    endcase
  endfunction

  csr_access_check #(.ADDR_WIDTH(ADDR_WIDTH), .WRITE_PREMISSION(1'b0)) u_rd_check (
    .addr (addr_q),
    .ok   (rd_ok)
  );

  csr_access_check #(.ADDR_WIDTH(ADDR_WIDTH), .WRITE_PREMISSION(1'b1)) u_wr_check (
    .addr (addr_q),
    .ok   (wr_ok)
  );

  // The CSR file read port always follows the latched address; it is sampled in CHECK.
  assign csrf_raddr = addr_q;

  always_comb begin
    state_d      = state_q;
    req_ready    = 1'b0;
    accept       = 1'b0;
    csrf_we      = 1'b0;
    csrf_waddr   = '0;
    csrf_wdata   = '0;
    resp_valid   = 1'b0;
    resp_rdata   = '0;
    resp_illegal = 1'b0;
    illegal      = !rd_ok || (wr_en_q && !wr_ok) || (op_q == CSR_OP_RSVD);

    case (state_q)
      IDLE: begin
        req_ready = !flush;
        accept    = req_valid && !flush;
        if (accept) state_d = CHECK;
      end
      CHECK: begin
        state_d = illegal ? RESP : WRITE;
      end
      WRITE: begin
        csrf_we    = wr_en_q && !flush;
        csrf_waddr = addr_q;
        csrf_wdata = rmw_data(op_q, old_q, src_q);
        state_d    = RESP;
      end
      RESP: begin
        resp_valid   = 1'b1;
        resp_illegal = illegal_q;
        resp_rdata   = illegal_q ? '0 : old_q;
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Flush overrides every other transition, including a pending response handshake.
    if (flush) state_d = IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      op_q      <= CSR_OP_RSVD;
      addr_q    <= '0;
      src_q     <= '0;
      wr_en_q   <= 1'b0;
      old_q     <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q    <= csr_op_t'(req_op);
        addr_q  <= req_addr;
        src_q   <= req_src;
        wr_en_q <= req_wr_en;
      end
      if (state_q == CHECK) begin
        old_q     <= csrf_rdata;
        illegal_q <= illegal;
      end
    end
  end

endmodule

// File: doc/csr_access_sequencer.md
# csr_access_sequencer

Multi-cycle controller that executes one Zicsr instruction (CSRRW/CSRRS/CSRRC, register or zimm form) at a time against the CSR file. It sits between the commit-side CSR instruction issue and the CSR file. It sequences each instruction through four steps: permission check, old-value read, read-modify-write, and result return. It flags illegal accesses instead of writing, and it honours a pipeline flush at any point.

## Interface
Parameters:
- DATA_WIDTH, default 32: CSR data width.
- ADDR_WIDTH, default `CSR_ADDR_WIDTH (12): CSR address width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; synchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  sequencer accepts a request this cycle.
- req_op  in  2  operation: 1 = RW, 2 = RS, 3 = RC, 0 = reserved.
- req_addr  in  ADDR_WIDTH  CSR address.
- req_src  in  DATA_WIDTH  rs1 value, or zero-extended zimm.
- req_wr_en  in  1  write intended; RW is always 1; RS/RC only when rs1/zimm ≠ 0.
- flush  in  1  abort the in-flight instruction.
- csrf_raddr  out  ADDR_WIDTH  CSR file read address.
- csrf_rdata  in  DATA_WIDTH  CSR file read data; combinational, same cycle.
- csrf_we  out  1  CSR file write strobe.
- csrf_waddr  out  ADDR_WIDTH  CSR file write address.
- csrf_wdata  out  DATA_WIDTH  CSR file write data.
- resp_valid  out  1  result available.
- resp_ready  in  1  consumer takes the result.
- resp_rdata  out  DATA_WIDTH  old CSR value, to be written to rd.
- resp_illegal  out  1  illegal-instruction flag.

## Operation
States:
- IDLE: req_ready = !flush. A handshake (req_valid & req_ready) latches op/addr/src/wr_en and moves to CHECK.
- CHECK:
  - csrf_raddr = latched addr; capture csrf_rdata into old_q.
  - illegal = !rd_ok | (wr_en & !wr_ok) | (op == 0).
  - illegal → RESP with resp_illegal = 1; otherwise → WRITE.
- WRITE:
  - csrf_we = wr_en & !flush, with csrf_waddr = addr.
  - csrf_wdata: RW = src; RS = old_q | src; RC = old_q & ~src.
  - Always proceeds to RESP.
- RESP: resp_valid = 1 and resp_rdata = old_q (0 when illegal). Holds until resp_ready; then → IDLE.
- flush: from any non-IDLE state, next state is IDLE. It suppresses csrf_we in the same cycle and drops resp_valid on the next edge. Flush has priority over every other transition.
- rd_ok / wr_ok come from two csr_access_check instances on the latched addr: WRITE_PREMISSION = 0 (read check) and 1 (write check).
- csrf_we, csrf_waddr, csrf_wdata are only meaningful when csrf_we = 1. The write addr/data outputs read 0 outside WRITE.

## Timing
- Reset (rst_n low at a clk edge): state = IDLE, old_q = 0, all latched fields = 0.
  - Outputs after reset: req_ready = 1, resp_valid = 0, resp_illegal = 0, csrf_we = 0, resp_rdata = 0.
  - Reset mid-operation discards the instruction without a write.
- Latency, with acceptance at edge E0:
  - Legal instruction: CHECK in cycle E0+1, WRITE in E0+2, resp_valid from E0+3.
  - Illegal instruction: resp_valid from E0+2; csrf_we never asserts.
- csrf_we asserts for exactly one cycle per legal instruction with wr_en = 1. It asserts zero cycles when wr_en = 0, so a read-only RS/RC has no write side effects.
- Throughput: next accept no earlier than the cycle after the resp handshake. req_ready = 0 in all non-IDLE states.
- resp_valid with resp_ready low: resp_rdata and resp_illegal stay stable, and no further state change occurs.
- flush together with req_valid in IDLE: no accept.
- flush together with resp_ready in RESP: go to IDLE; the response counts as discarded.

## Structure
- Package csr_seq_pkg holds:
  - csr_op_t enum: CSR_OP_RSVD = 0, CSR_OP_RW = 1, CSR_OP_RS = 2, CSR_OP_RC = 3.
  - csr_seq_state_t enum: IDLE, CHECK, WRITE, RESP.
- Sub-modules: reuse the existing csr_access_check twice; no new sub-module.
- A single always_ff handles state and latches; a single always_comb handles next-state and outputs.

## Test plan
- RW, addr 0x340 (mscratch), src 0xDEADBEEF, CSR holds 0x12345678:
  - One csrf_we pulse with data 0xDEADBEEF at E0+2.
  - resp_rdata = 0x12345678 at E0+3, resp_illegal = 0.
- RS with src 0x0000_0088 on 0x300 holding 0x1800: wdata = 0x1888. Then RC with src 0x8 on the same CSR: wdata = 0x1880.
- RS with wr_en = 0 on 0xF11 (mvendorid): no csrf_we, resp_rdata = CSR value, resp_illegal = 0. The same with RW (wr_en = 1): resp_illegal = 1 at E0+2, no csrf_we.
- Unknown addr 0x7FF, and op = 0 on a valid addr: both give resp_illegal = 1, resp_rdata = 0, no write.
- flush asserted during WRITE: csrf_we stays 0, the next cycle is IDLE with req_ready = 1, and resp_valid never asserts.
- resp_ready held low for 5 cycles, then high: response stable throughout. A new request is accepted on the cycle after the handshake, and back-to-back requests complete in order.
